// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// New images are double-buffered and only take effect at frame boundaries.
module seg_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*N_DIGITS-1:0] load_value,
  input  logic [N_DIGITS-1:0]   load_dp,
  input  logic [N_DIGITS-1:0]   load_en,
  output logic [6:0]            sevenSeg,
  output logic                  dp,
  output logic [7:0]            anodes,
  output logic [2:0]            digit_idx,
  output logic                  frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK  = CNT_W'(BLANK_CYCLES);
  localparam logic [2:0]       LAST_DIGIT = 3'(N_DIGITS - 1);

  logic [CNT_W-1:0]             cnt;
  logic [CNT_W-1:0]             cnt_next;
  logic [2:0]                   idx_next;
  logic                         slot_wrap;
  logic                         frame_wrap;
  logic                         accept;
  logic                         apply_pending;
  logic                         show_next;

  logic [N_DIGITS-1:0][3:0]     shadow_value;
  logic [N_DIGITS-1:0][3:0]     shadow_value_next;
  logic [N_DIGITS-1:0]          shadow_dp;
  logic [N_DIGITS-1:0]          shadow_dp_next;
  logic [N_DIGITS-1:0]          shadow_en;
  logic [N_DIGITS-1:0]          shadow_en_next;

  logic [N_DIGITS-1:0][3:0]     pending_value;
  logic [N_DIGITS-1:0]          pending_dp;
  logic [N_DIGITS-1:0]          pending_en;
  logic                         pending_full;

  logic [6:0]                   seg_next;
  logic                         dp_next;
  logic [7:0]                   anodes_next;

  function automatic logic [6:0] hex_decode(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex_decode = 7'b0000001;
      4'h1:    hex_decode = 7'b1001111;
      4'h2:    hex_decode = 7'b0010010;
      4'h3:    hex_decode = 7'b0000110;
      4'h4:    hex_decode = 7'b1001100;
      4'h5:    hex_decode = 7'b0100100;
      4'h6:    hex_decode = 7'b0100000;
      4'h7:    hex_decode = 7'b0001111;
      4'h8:    hex_decode = 7'b0000000;
      4'h9:    hex_decode = 7'b0000100;
      4'hA:    hex_decode = 7'b0001000;
      4'hB:    hex_decode = 7'b1100000;
      4'hC:    hex_decode = 7'b0110001;
      4'hD:    hex_decode = 7'b1000010;
      4'hE:    hex_decode = 7'b0110000;
      default: hex_decode = 7'b0111000;
    endcase
  endfunction

  assign load_ready    = ~pending_full;
  assign accept        = load_valid & ~pending_full;
  assign slot_wrap     = (cnt == CNT_LAST);
  assign frame_wrap    = slot_wrap & (digit_idx == LAST_DIGIT);
  assign apply_pending = frame_wrap & pending_full;

  // Outputs are registered from the next-cycle scan position and image, so
  // each cycle's segments/anodes match that cycle's cnt, digit and shadow.
  always_comb begin
    cnt_next          = slot_wrap ? '0 : cnt + CNT_W'(1);
    idx_next          = digit_idx;
    shadow_value_next = shadow_value;
    shadow_dp_next    = shadow_dp;
    shadow_en_next    = shadow_en;
    seg_next          = 7'h7F;
    dp_next           = 1'b1;
    anodes_next       = 8'hFF;

    if (slot_wrap) begin
      idx_next = frame_wrap ? 3'd0 : digit_idx + 3'd1;
    end

    if (apply_pending) begin
      shadow_value_next = pending_value;
      shadow_dp_next    = pending_dp;
      shadow_en_next    = pending_en;
    end

    show_next = (cnt_next >= CNT_BLANK);
    if (show_next) begin
      seg_next = hex_decode(shadow_value_next[idx_next]);
      dp_next  = ~shadow_dp_next[idx_next];
      if (shadow_en_next[idx_next]) begin
        anodes_next[idx_next] = 1'b0;
      end
    end
  end

  // Scan position, image buffers and display registers share one clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      digit_idx     <= 3'd0;
      frame_tick    <= 1'b0;
      anodes        <= 8'hFF;
      sevenSeg      <= 7'h7F;
      dp            <= 1'b1;
      shadow_value  <= '0;
      shadow_dp     <= '0;
      shadow_en     <= '0;
      pending_value <= '0;
      pending_dp    <= '0;
      pending_en    <= '0;
      pending_full  <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      digit_idx    <= idx_next;
      frame_tick   <= frame_wrap;
      anodes       <= anodes_next;
      sevenSeg     <= seg_next;
      dp           <= dp_next;
      shadow_value <= shadow_value_next;
      shadow_dp    <= shadow_dp_next;
      shadow_en    <= shadow_en_next;

      // Accept and apply never coincide: accept needs an empty buffer.
      if (accept) begin
        pending_value <= load_value;
        pending_dp    <= load_dp;
        pending_en    <= load_en;
        pending_full  <= 1'b1;
      end else if (apply_pending) begin
        pending_full  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-count reference model predicts
// every cycle's outputs into a queue, a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam int ND    = 8;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_value = 32'h0;
  logic [7:0]  load_dp = 8'h0;
  logic [7:0]  load_en = 8'h0;
  logic [6:0]  sevenSeg;
  logic        dp;
  logic [7:0]  anodes;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic [2:0] idx;
    logic       tick;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model state: cycles since reset release plus the two images.
  int unsigned m_cyc;
  logic [3:0]  m_val [ND];
  logic [7:0]  m_dp;
  logic [7:0]  m_en;
  logic [3:0]  p_val [ND];
  logic [7:0]  p_dp;
  logic [7:0]  p_en;
  bit          p_full;

  seg_scan_ctrl #(
    .N_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .load_dp(load_dp), .load_en(load_en),
    .sevenSeg(sevenSeg), .dp(dp), .anodes(anodes),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t resetItem();
    exp_t e;
    e.seg = 7'h7F; e.dp = 1'b1; e.an = 8'hFF; e.idx = 3'd0; e.tick = 1'b0; e.rdy = 1'b1;
    return e;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int slot;
    int dig;
    logic [2:0] d3;
    slot  = int'(m_cyc % RD);
    dig   = int'((m_cyc / RD) % ND);
    d3    = dig[2:0];
    e.idx = d3;
    e.rdy = !p_full;
    e.tick = (m_cyc > 0) && (m_cyc % FRAME == 0);
    if (slot < BC) begin
      e.seg = 7'h7F; e.dp = 1'b1; e.an = 8'hFF;
    end else begin
      e.seg = SEG_TAB[m_val[dig]];
      e.dp  = !m_dp[dig];
      e.an  = m_en[dig] ? ~(8'd1 << dig) : 8'hFF;
    end
    return e;
  endfunction

  task automatic modelReset();
    m_cyc = 0; m_dp = 8'h0; m_en = 8'h0; p_dp = 8'h0; p_en = 8'h0; p_full = 0;
    for (int i = 0; i < ND; i++) begin
      m_val[i] = 4'h0;
      p_val[i] = 4'h0;
    end
  endtask

  // Reference model: advances one cycle per active edge and queues the
  // expected outputs of the cycle that edge starts.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      modelReset();
      sb.delete();
      if (clk) sb.push_back(resetItem());
    end else begin
      bit old_full;
      old_full = p_full;
      m_cyc++;
      if (old_full && (m_cyc % FRAME == 0)) begin
        for (int i = 0; i < ND; i++) m_val[i] = p_val[i];
        m_dp = p_dp;
        m_en = p_en;
        p_full = 0;
      end
      if (load_valid && !old_full) begin
        for (int i = 0; i < ND; i++) p_val[i] = load_value[4*i +: 4];
        p_dp = load_dp;
        p_en = load_en;
        p_full = 1;
      end
      sb.push_back(predict());
    end
  end

  // Monitor: one expected item per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: no expected item, got 1 expected 0 at %0t", $time);
    end else begin
      e = sb.pop_front();
      checkOutput("sevenSeg",   32'(sevenSeg),   32'(e.seg));
      checkOutput("dp",         32'(dp),         32'(e.dp));
      checkOutput("anodes",     32'(anodes),     32'(e.an));
      checkOutput("digit_idx",  32'(digit_idx),  32'(e.idx));
      checkOutput("frame_tick", 32'(frame_tick), 32'(e.tick));
      checkOutput("load_ready", 32'(load_ready), 32'(e.rdy));
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitPhase(input int target);
    int n;
    for (n = 0; n < 4 * FRAME; n++) begin
      if (m_cyc % FRAME == target) break;
      @(posedge clk);
      #1;
    end
    if (n == 4 * FRAME) checkOutput("phase_timeout", 32'(m_cyc % FRAME), 32'(target));
  endtask

  // Offer an image and hold it until the DUT takes it; then scramble the bus.
  task automatic applyStimulus(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e);
    bit acc;
    int n;
    load_value = v; load_dp = d; load_en = e; load_valid = 1'b1;
    acc = 0;
    for (n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = load_ready;
      @(posedge clk);
    end
    #1;
    load_valid = 1'b0;
    load_value = $urandom;
    load_dp    = 8'($urandom);
    load_en    = 8'($urandom);
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    waitCycles(70);

    applyStimulus(32'h89ABCDEF, 8'h01, 8'hFF);
    waitCycles(2 * FRAME);

    waitPhase(3 * RD);
    applyStimulus(32'h11111111, 8'($urandom), 8'hFF);
    applyStimulus($urandom, 8'($urandom), 8'hFF);
    waitCycles(2 * FRAME + 10);

    applyStimulus($urandom, 8'($urandom), 8'b0000_0101);
    waitCycles(2 * FRAME);

    for (int k = 0; k < 6; k++) begin
      applyStimulus($urandom, 8'($urandom), 8'($urandom));
      waitCycles(int'($urandom_range(0, 90)));
    end

    applyStimulus($urandom, 8'($urandom), 8'hFF);
    waitCycles(2 * FRAME);

    waitPhase(5 * RD + 4);
    reset = 1'b0;
    #1;
    checkOutput("async_anodes",    32'(anodes),     32'hFF);
    checkOutput("async_sevenSeg",  32'(sevenSeg),   32'h7F);
    checkOutput("async_dp",        32'(dp),         32'h1);
    checkOutput("async_digit_idx", 32'(digit_idx),  32'h0);
    checkOutput("async_ready",     32'(load_ready), 32'h1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    waitCycles(FRAME + 10);

    applyStimulus($urandom, 8'($urandom), 8'($urandom));
    waitCycles(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit seven-segment display on the board; drives shared active-low segment lines and active-low anodes.
- Holds a display image (hex nibbles, decimal points, digit enables) and applies new images only at frame boundaries, so digits never tear.
- Each digit slot starts with a blanking guard interval to suppress ghosting.
- Upstream logic (counters, FSM status) loads images through a valid/ready handshake.

Parameters:
N_DIGITS, 8, number of digits scanned (1..8); anodes[7:N_DIGITS] held high
REFRESH_DIV, 100000, clk cycles per digit slot (>= 2)
BLANK_CYCLES, 1000, guard cycles at start of each slot, all off (1 <= BLANK_CYCLES < REFRESH_DIV)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
load_valid  in  1  new image offered
load_ready  out  1  pending buffer empty; image accepted when load_valid && load_ready
load_value  in  4*N_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i]
load_dp  in  N_DIGITS  decimal point per digit, 1 = lit
load_en  in  N_DIGITS  digit enable, 1 = shown
sevenSeg  out  7  segments {a,b,c,d,e,f,g}, bit6 = a, active-low
dp  out  1  decimal point, active-low
anodes  out  8  digit select, active-low, at most one low
digit_idx  out  3  digit currently scanned
frame_tick  out  1  one-cycle pulse on frame boundary

Behaviour:
- Reset (reset low, async):
  - cnt = 0, digit_idx = 0, anodes = 8'hFF, sevenSeg = 7'h7F, dp = 1, frame_tick = 0.
  - Shadow image = 0, shadow enables = 0 (display dark), pending empty, load_ready = 1.
  - Deassertion mid-slot restarts scan at digit 0, cnt 0.
- Slot counter:
  - cnt counts 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV).
  - At cnt == REFRESH_DIV-1, cnt wraps to 0 and digit_idx increments modulo N_DIGITS.
- Output phases:
  - Blank phase (cnt < BLANK_CYCLES): anodes = FF, sevenSeg = 7F, dp = 1.
  - Show phase (cnt >= BLANK_CYCLES): anodes[digit_idx] = 0 only if shadow enable[digit_idx] = 1, else FF.
  - Show phase segments: sevenSeg = hex decode of shadow nibble; dp = ~shadow_dp[digit_idx].
  - Disabled digits still consume their full slot.
- Output registers:
  - sevenSeg, dp and anodes are registers, updated on the same edge as cnt/digit_idx.
  - Their value in any cycle is a function of that cycle's cnt, digit_idx and shadow only; no combinational path from any input.
- Hex decode (active-low, g = LSB):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- Frame boundary: the edge where digit_idx wraps N_DIGITS-1 -> 0 and cnt wraps to 0. frame_tick is high for the first cycle of the new frame.
- Handshake:
  - One-entry pending buffer; load_ready = ~pending_full.
  - On accept, capture load_value/dp/en into pending and set pending_full.
  - At a frame boundary with pending_full: copy pending -> shadow and clear pending_full; the new image is visible from digit 0 of the new frame, and load_ready rises in that same first cycle.
  - Accept coinciding with a boundary while pending was empty: data goes to pending and is applied at the next boundary.
  - load_valid while not ready is ignored; the upstream must hold its data.
  - Inputs are not sampled unless accepted.
- Invariant: never more than one anode low; no anode low during any blank phase, including across the frame boundary.

Test Plan:
(Params for all scenarios: N_DIGITS=8, REFRESH_DIV=8, BLANK_CYCLES=2, frame = 64 cycles.)
- Reset: hold reset low, toggle clk -> anodes=FF, sevenSeg=7F, dp=1, load_ready=1. Release and run 64 cycles -> anodes stay FF (enables 0), frame_tick pulses once at cycle 64.
- Load: load value 32'h89ABCDEF, en=FF, dp=01 -> digit 0 slot shows 0111000 (F) with dp=0 for cycles 2..7 only, anodes=FE. Digit 7 slot shows 0000000 (8), anodes=7F. Every slot has exactly 2 blank cycles.
- Tear-free update: mid-frame (digit 3) load 32'h11111111 -> digits 3..7 keep the old image, load_ready=0 until the boundary, and the new image appears from digit 0 of the next frame.
- Backpressure: second load_valid while pending full -> not accepted, shadow unchanged. Once held until the boundary, it is accepted the cycle after load_ready rises and shown at the following boundary.
- Enable mask: en=8'b0000_0101 -> anodes go low only during the show phase of slots 0 and 2. Slot timing is unchanged, and frame_tick period stays 64.
- Async reset mid-show: assert reset at digit 5, cnt 4 -> outputs go blank immediately without a clock edge, the image is cleared, and the scan restarts at digit 0 after release.
